// File: rtl/compare_pipe.sv
// Two-stage streaming comparator: CHANNELS lanes of A op B per beat with
// valid/ready on both sides and per-lane saturating hit counters.
module compare_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [2:0]                  op_i,
    input  logic                        signed_i,
    input  logic [CHANNELS*WIDTH-1:0]   a_i,
    input  logic [CHANNELS*WIDTH-1:0]   b_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CHANNELS-1:0]         q_o,
    input  logic                        cnt_clr_i,
    output logic [CHANNELS*CNT_W-1:0]   hit_cnt_o
);

    localparam int unsigned DATA_W = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] OP_LT = 3'd0;
    localparam logic [2:0] OP_LE = 3'd1;
    localparam logic [2:0] OP_GT = 3'd2;
    localparam logic [2:0] OP_GE = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic              sgn;
    } s1_t;

    logic                             s1_valid_q, s1_valid_d;
    s1_t                              s1_q, s1_d;
    logic                             out_valid_q, out_valid_d;
    logic [CHANNELS-1:0]              q_q, q_d;
    logic [CHANNELS-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic                en1, en2, out_hs;
    logic [CHANNELS-1:0] cmp_res;

    // Signed compare reuses the unsigned comparator by flipping both sign bits.
    function automatic logic lane_cmp(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [2:0]       op,
                                      input logic             sgn);
        logic [WIDTH-1:0] ak;
        logic [WIDTH-1:0] bk;
        logic             lt;
        logic             eq;
        ak = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
        bk = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
        lt = (ak < bk);
        eq = (a == b);
        case (op)
            OP_LT:   lane_cmp = lt;
            OP_LE:   lane_cmp = lt | eq;
            OP_GT:   lane_cmp = ~(lt | eq);
            OP_GE:   lane_cmp = ~lt;
            OP_EQ:   lane_cmp = eq;
            OP_NE:   lane_cmp = ~eq;
            default: lane_cmp = 1'b0;
        endcase
    endfunction

    always_comb begin
        cmp_res = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cmp_res[k] = lane_cmp(s1_q.a[k*WIDTH +: WIDTH], s1_q.b[k*WIDTH +: WIDTH],
                                  s1_q.op, s1_q.sgn);
        end
    end

    // Pipeline advance: a stage moves when it is empty or the stage after it moves.
    always_comb begin
        en2         = !out_valid_q || out_ready_i;
        en1         = !s1_valid_q || en2;
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        if (en1) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_d.a   = a_i;
                s1_d.b   = b_i;
                s1_d.op  = op_i;
                s1_d.sgn = signed_i;
            end
        end
        if (en2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                q_d = cmp_res;
            end
        end
    end

    // Hit counters: clear dominates, otherwise saturating increment on handshake.
    always_comb begin
        out_hs = out_valid_q && out_ready_i;
        cnt_d  = cnt_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (cnt_clr_i) begin
                cnt_d[k] = '0;
            end else if (out_hs && q_q[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o  = en1;
    assign out_valid_o = out_valid_q;
    assign q_o         = q_q;
    assign hit_cnt_o   = cnt_q;

endmodule

// File: tb/tb_compare_pipe.sv
// Directed bench for compare_pipe: vector table plus stall, counter and reset sequences.
module tb_compare_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned CH = 4;
    localparam int unsigned DW = CH * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready, in_ready2;
    logic [2:0]      op;
    logic            sgn;
    logic [DW-1:0]   a, b;
    logic            out_valid, out_valid2;
    logic            out_ready;
    logic [CH-1:0]   q, q2;
    logic            cnt_clr;
    logic [CH*8-1:0] hit1;
    logic [CH*2-1:0] hit2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    compare_pipe dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .signed_i(sgn), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .q_o(q),
        .cnt_clr_i(cnt_clr), .hit_cnt_o(hit1)
    );

    compare_pipe #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .op_i(op), .signed_i(sgn), .a_i(a), .b_i(b),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .q_o(q2),
        .cnt_clr_i(cnt_clr), .hit_cnt_o(hit2)
    );

    typedef struct {
        logic [2:0]  op;
        logic        sgn;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  q;      // {lane1, lane0}
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Lane k gets A=0,B=1 (true under unsigned lt) where p[k]=1, else A=1,B=1.
    function automatic logic [DW-1:0] pat_a(input logic [3:0] p);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*W +: W] = W'(!p[k]);
        return r;
    endfunction

    function automatic logic [DW-1:0] ones_b();
        logic [DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*W +: W] = W'(1);
        return r;
    endfunction

    // Sends one beat with out_ready=1 and returns the result and edges from accept to out_valid.
    task automatic run_beat(input logic [2:0] o, input logic s, input logic [DW-1:0] av,
                            input logic [DW-1:0] bv, input logic clr,
                            output logic [CH-1:0] qs, output int lat);
        int n;
        op = o; sgn = s; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        qs = q;
        cnt_clr = clr;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        logic [CH-1:0]   qs;
        int              lat;
        int              c1[CH];
        int              c2[CH];
        logic [CH-1:0]   eq;
        logic [CH*8-1:0] e1;
        logic [CH*2-1:0] e2;
        logic [3:0]      pats[6];
        logic [3:0]      expq[$];
        logic [3:0]      prev_q;
        logic            prev_stall;
        logic            hs_in, hs_out;
        int              pushed, popped, saw_low;
        logic [1:0]      seq[5];

        vecs[0]  = '{3'd0, 1'b0, 32'h1,        32'hFFFF_FFFF, 32'h5,         32'h5,         2'b01};
        vecs[1]  = '{3'd0, 1'b1, 32'h1,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10};
        vecs[2]  = '{3'd2, 1'b1, 32'h1,        32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01};
        vecs[3]  = '{3'd4, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,        32'h1,         2'b01};
        vecs[4]  = '{3'd1, 1'b0, 32'h7,        32'h7,         32'h8,         32'h7,         2'b01};
        vecs[5]  = '{3'd3, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,        32'h1,         2'b01};
        vecs[6]  = '{3'd3, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10};
        vecs[7]  = '{3'd5, 1'b1, 32'h1,        32'h2,         32'h3,         32'h3,         2'b01};
        vecs[8]  = '{3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,         32'h0,         2'b01};
        vecs[9]  = '{3'd1, 1'b1, 32'h8000_0000, 32'h0,        32'h0,         32'h8000_0000, 2'b01};
        vecs[10] = '{3'd6, 1'b0, 32'h5,        32'h3,         32'h0,         32'h0,         2'b00};
        vecs[11] = '{3'd7, 1'b1, 32'h1,        32'hFFFF_FFFF, 32'h5,         32'h9,         2'b00};
        vecs[12] = '{3'd4, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11};
        vecs[13] = '{3'd5, 1'b0, 32'h0,        32'h8000_0000, 32'h1,         32'h1,         2'b01};
        vecs[14] = '{3'd2, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11};

        rst = 1'b1; in_valid = 1'b0; op = '0; sgn = 1'b0; a = '0; b = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_q", 64'(q), 64'd0);
        chk("reset_hit", 64'(hit1), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < CH; k++) begin c1[k] = 0; c2[k] = 0; end

        // Table vectors with a running saturating-count model for both counter widths.
        for (int i = 0; i < NV; i++) begin
            run_beat(vecs[i].op, vecs[i].sgn,
                     {vecs[i].a1, vecs[i].a0, vecs[i].a1, vecs[i].a0},
                     {vecs[i].b1, vecs[i].b0, vecs[i].b1, vecs[i].b0}, 1'b0, qs, lat);
            eq = {vecs[i].q[1], vecs[i].q[0], vecs[i].q[1], vecs[i].q[0]};
            chk($sformatf("vec%0d_q", i), 64'(qs), 64'(eq));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            for (int k = 0; k < CH; k++) begin
                if (eq[k]) begin
                    if (c1[k] < 255) c1[k]++;
                    if (c2[k] < 3)   c2[k]++;
                end
                e1[k*8 +: 8] = 8'(c1[k]);
                e2[k*2 +: 2] = 2'(c2[k]);
            end
            chk($sformatf("vec%0d_hit8", i), 64'(hit1), 64'(e1));
            chk($sformatf("vec%0d_hit2", i), 64'(hit2), 64'(e2));
        end

        // Six back-to-back beats with a three-cycle output stall.
        pats[0] = 4'h1; pats[1] = 4'h2; pats[2] = 4'h4;
        pats[3] = 4'h8; pats[4] = 4'h5; pats[5] = 4'hA;
        pushed = 0; popped = 0; saw_low = 0; prev_stall = 1'b0; prev_q = '0;
        op = 3'd0; sgn = 1'b0; b = ones_b();
        for (int c = 0; c < 40 && popped < 6; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (pushed < 6) begin
                a = pat_a(pats[pushed]); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (prev_stall) begin
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
                chk("stall_hold_q", 64'(q), 64'(prev_q));
            end
            if (!in_ready) begin
                saw_low++;
                chk("full_inflight", 64'(pushed - popped), 64'd2);
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (expq.size() == 0) begin
                    chk("stream_unexpected_beat", 64'(q), 64'hDEAD);
                end else begin
                    chk($sformatf("stream_q%0d", popped), 64'(q), 64'(expq.pop_front()));
                end
                popped++;
            end
            if (hs_in) begin
                expq.push_back(pats[pushed]);
                pushed++;
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = q;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(popped), 64'd6);
        chk("stream_ready_dropped", 64'(saw_low != 0), 64'd1);
        for (int c = 0; c < 3; c++) begin
            chk("stream_no_extra", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Counter clear, saturation with CNT_W=2, and clear beating an increment.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_hit8", 64'(hit1), 64'd0);
        chk("clr_hit2", 64'(hit2), 64'd0);
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            run_beat(3'd0, 1'b0, pat_a(4'h2), ones_b(), 1'b0, qs, lat);
            chk($sformatf("sat_lane1_%0d", i), 64'(hit2[2 +: 2]), 64'(seq[i]));
            chk($sformatf("sat_others_%0d", i), 64'({hit2[6 +: 2], hit2[4 +: 2], hit2[0 +: 2]}), 64'd0);
        end
        chk("sat_hit8_lane1", 64'(hit1[8 +: 8]), 64'd5);
        run_beat(3'd0, 1'b0, pat_a(4'h2), ones_b(), 1'b1, qs, lat);
        chk("clr_wins_q", 64'(qs), 64'h2);
        chk("clr_wins_hit2", 64'(hit2), 64'd0);
        chk("clr_wins_hit8", 64'(hit1), 64'd0);

        // Reserved op with all lanes otherwise true: no hits.
        run_beat(3'd6, 1'b0, pat_a(4'hF), ones_b(), 1'b0, qs, lat);
        chk("reserved_q", 64'(qs), 64'd0);
        chk("reserved_hit", 64'(hit1), 64'd0);

        // Reset with beats in both stages.
        run_beat(3'd0, 1'b0, pat_a(4'hF), ones_b(), 1'b0, qs, lat);
        chk("pre_reset_hit", 64'(hit1), 64'h0101_0101);
        out_ready = 1'b0;
        a = pat_a(4'h5); in_valid = 1'b1;
        @(posedge clk); #1;
        a = pat_a(4'hA);
        @(posedge clk); #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        chk("pre_reset_ready", 64'(in_ready), 64'd0);
        a = pat_a(4'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_hit8", 64'(hit1), 64'd0);
        chk("rst_hit2", 64'(hit2), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
